// File: rtl/trace_line_serializer.sv
// Trace line serializer: captures one packed trace line per handshake and
// streams its characters MSB-byte first over a val/rdy byte port, with optional newline.
module trace_line_serializer #(
    parameter int unsigned NCHARS    = 512,
    parameter bit          APPEND_NL = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                line_val,
    output logic                line_rdy,
    input  logic [NCHARS*8-1:0] line_msg,
    output logic                out_val,
    input  logic                out_rdy,
    output logic [7:0]          out_msg,
    output logic                busy,
    output logic [15:0]         line_count
);

    localparam int unsigned     PTRW     = $clog2(NCHARS);
    localparam logic [15:0]     LAST_IDX = 16'(NCHARS - 1);
    localparam logic [PTRW-1:0] TOP_PTR  = PTRW'(NCHARS - 1);
    localparam logic [7:0]      NL_CHAR  = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_NL
    } state_t;

    state_t              state;
    logic [NCHARS*8-1:0] line_q;
    logic [PTRW-1:0]     ptr;
    logic [PTRW-1:0]     lo_ptr;

    logic [15:0]     idx0;
    logic            line_empty;
    logic [PTRW-1:0] lo_next;
    logic [PTRW-1:0] ptr_dec;
    logic [7:0]      first_char;
    logic [7:0]      next_char;
    logic            last_beat;

    // Bytes 1:0 carry the index field, so the lowest character is never below byte 2.
    always_comb begin
        idx0       = line_msg[15:0];
        line_empty = (idx0 >= LAST_IDX);
        lo_next    = (idx0 <= 16'd1) ? PTRW'(2) : PTRW'(idx0 + 16'd1);
        first_char = line_msg[NCHARS*8-8 +: 8];
        ptr_dec    = ptr - 1'b1;
        next_char  = line_q[{ptr_dec, 3'b000} +: 8];
        last_beat  = (ptr == lo_ptr);
    end

    // First byte is taken straight from line_msg so it appears the cycle after accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            line_q     <= '0;
            ptr        <= '0;
            lo_ptr     <= '0;
            line_rdy   <= 1'b1;
            out_val    <= 1'b0;
            out_msg    <= '0;
            busy       <= 1'b0;
            line_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (line_val) begin
                        line_q <= line_msg;
                        lo_ptr <= lo_next;
                        ptr    <= TOP_PTR;
                        if (!line_empty) begin
                            state    <= ST_SEND;
                            out_val  <= 1'b1;
                            out_msg  <= first_char;
                            line_rdy <= 1'b0;
                            busy     <= 1'b1;
                        end else if (APPEND_NL) begin
                            state    <= ST_NL;
                            out_val  <= 1'b1;
                            out_msg  <= NL_CHAR;
                            line_rdy <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            line_count <= line_count + 16'd1;
                        end
                    end
                end
                ST_SEND: begin
                    if (out_rdy) begin
                        if (!last_beat) begin
                            ptr     <= ptr_dec;
                            out_msg <= next_char;
                        end else if (APPEND_NL) begin
                            state   <= ST_NL;
                            out_msg <= NL_CHAR;
                        end else begin
                            state      <= ST_IDLE;
                            out_val    <= 1'b0;
                            out_msg    <= '0;
                            line_rdy   <= 1'b1;
                            busy       <= 1'b0;
                            line_count <= line_count + 16'd1;
                        end
                    end
                end
                ST_NL: begin
                    if (out_rdy) begin
                        state      <= ST_IDLE;
                        out_val    <= 1'b0;
                        out_msg    <= '0;
                        line_rdy   <= 1'b1;
                        busy       <= 1'b0;
                        line_count <= line_count + 16'd1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    out_val  <= 1'b0;
                    out_msg  <= '0;
                    line_rdy <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
